// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: control-bundle bit positions and NOP/zero constants.
package mips_pipe_pkg;

  localparam int CTRL_W = 10;

  localparam int REG_WRITE  = 0;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 2;
  localparam int MEM_TO_REG = 3;
  localparam int ALU_SRC    = 4;
  localparam int REG_DST    = 5;
  localparam int ALU_OP_LSB = 6;
  localparam int ALU_OP_MSB = 9;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use comparator: a load in flight whose destination matches either source of the next instruction.
module hazard_detect
  import mips_pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              memRead,
  input  logic [REG_AW-1:0] destReg,
  input  logic [REG_AW-1:0] srcA,
  input  logic [REG_AW-1:0] srcB,
  output logic              hazard
);

  // Loads into $zero are discarded, so they never create a dependency.
  assign hazard = memRead
                  && (destReg != REG_AW'(REG_ZERO))
                  && ((destReg == srcA) || (destReg == srcB));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Define WB_BYPASS_EN to compile in the WB-to-ID write-through bypass of the operands.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = mips_pipe_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [15:0]       id_imm,
  input  logic              id_zext,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              flush,
  input  logic              ext_stall,
  output logic              hazard_stall,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_data1,
  output logic [DATA_W-1:0] ex_data2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_pc4
);

  import mips_pipe_pkg::*;

  logic              loadUse;
  logic [DATA_W-1:0] operand1;
  logic [DATA_W-1:0] operand2;
  logic [DATA_W-1:0] extImm;

  hazard_detect #(.REG_AW(REG_AW)) uHazard (
    .memRead (ex_ctrl[MEM_READ]),
    .destReg (ex_rt),
    .srcA    (id_rs),
    .srcB    (id_rt),
    .hazard  (loadUse)
  );

  assign hazard_stall = !reset && loadUse;

`ifdef WB_BYPASS_EN
  logic bypass1;
  logic bypass2;

  // Register file writes on the same edge we sample, so forward the WB value directly.
  assign bypass1  = wb_reg_write && (wb_write_reg != REG_AW'(REG_ZERO)) && (wb_write_reg == id_rs);
  assign bypass2  = wb_reg_write && (wb_write_reg != REG_AW'(REG_ZERO)) && (wb_write_reg == id_rt);
  assign operand1 = bypass1 ? wb_write_data : rf_data1;
  assign operand2 = bypass2 ? wb_write_data : rf_data2;
`else
  logic unusedWb;

  assign unusedWb = ^{wb_reg_write, wb_write_reg, wb_write_data};
  assign operand1 = rf_data1;
  assign operand2 = rf_data2;
`endif

  assign extImm = {{(DATA_W-16){id_imm[15] & ~id_zext}}, id_imm};

  // Flush and bubble both load the data fields; only the cleared control matters.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl  <= '0;
      ex_data1 <= '0;
      ex_data2 <= '0;
      ex_imm   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
      ex_pc4   <= '0;
    end else if (flush || !ext_stall) begin
      ex_ctrl  <= (flush || hazard_stall) ? CTRL_W'(CTRL_NOP) : id_ctrl;
      ex_data1 <= operand1;
      ex_data2 <= operand2;
      ex_imm   <= extImm;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rd    <= id_rd;
      ex_pc4   <= id_pc4;
    end
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS pipeline.
- Directly downstream of the register file. It latches ReadData1/ReadData2, the decoded instruction fields and the control bundle for the EX stage.
- Contains load-use hazard detection (bubble insertion and a stall request to PC/IF-ID), flush handling and a WB-to-ID write-through bypass. The bypass is needed because the register file writes on posedge and reads combinationally.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register address width
- CTRL_W, 10, control bundle width (field layout defined in package)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- id_rs  in  REG_AW  rs field of the instruction in ID
- id_rt  in  REG_AW  rt field
- id_rd  in  REG_AW  rd field
- id_imm  in  16  immediate field
- id_zext  in  1  1 = zero-extend the immediate, 0 = sign-extend
- id_ctrl  in  CTRL_W  decoded control bundle
- id_pc4  in  DATA_W  PC+4 of the ID instruction
- rf_data1  in  DATA_W  register-file read of rs
- rf_data2  in  DATA_W  register-file read of rt
- wb_reg_write  in  1  WB stage write enable
- wb_write_reg  in  REG_AW  WB destination register
- wb_write_data  in  DATA_W  WB write data
- flush  in  1  branch/jump resolved taken; squash the ID instruction
- ext_stall  in  1  downstream stall; hold all contents
- hazard_stall  out  1  combinational; freeze PC and IF/ID
- ex_ctrl  out  CTRL_W  registered control bundle
- ex_data1  out  DATA_W  registered rs operand
- ex_data2  out  DATA_W  registered rt operand
- ex_imm  out  DATA_W  registered extended immediate
- ex_rs  out  REG_AW  registered rs
- ex_rt  out  REG_AW  registered rt
- ex_rd  out  REG_AW  registered rd
- ex_pc4  out  DATA_W  registered PC+4

Behaviour:
- Reset: all ex_* outputs are 0 on the first posedge with reset=1. ex_ctrl=0 is a NOP (no reg_write, mem_read or mem_write).
- hazard_stall = ex_ctrl[MEM_READ] && ex_rt!=0 && (ex_rt==id_rs || ex_rt==id_rt). Purely combinational from the current registered state and ID inputs. Forced to 0 while reset=1.
- Update priority per posedge, highest first:
  1. reset: all outputs cleared.
  2. flush: ex_ctrl<=0. Data fields may load, but they are don't-care.
  3. ext_stall: hold every register unchanged.
  4. hazard_stall: bubble, ex_ctrl<=0. Other fields load normally (don't-care).
  5. Otherwise: load all fields.
- Latency: exactly 1 cycle from the ID inputs to the ex_* outputs.
- A bubble clears ex_ctrl[MEM_READ]. Therefore a load-use stall lasts exactly one cycle unless ext_stall is asserted.
- ext_stall together with hazard_stall: hold takes priority. hazard_stall stays asserted throughout, because the registered state is unchanged.
- Immediate extension:
  - ex_imm = {16{id_imm[15]}, id_imm} when id_zext=0.
  - ex_imm = {16'b0, id_imm} when id_zext=1.
- Operand selection (WB bypass): operand1 = wb_write_data if wb_reg_write && wb_write_reg!=0 && wb_write_reg==id_rs, else rf_data1. Operand2 uses the same rule with id_rt and rf_data2.
- Register 0 is never bypassed.
- Bypass has no effect on the hazard logic.

Optional Feature:
- WB_BYPASS_EN defined: the WB-to-ID bypass above is compiled in.
- WB_BYPASS_EN undefined: operands come straight from rf_data1/rf_data2. A same-cycle WB write is then not visible, and the toolchain must insert a NOP. Ports are identical in both builds; the wb_* inputs become unused.

Decomposition:
- Package mips_pipe_pkg holds:
  - Control-bundle bit indices: REG_WRITE=0, MEM_READ=1, MEM_WRITE=2, MEM_TO_REG=3, ALU_SRC=4, REG_DST=5, ALU_OP=9:6.
  - CTRL_W, CTRL_NOP=0.
  - REG_ZERO=0.
- One sub-module: hazard_detect. It is the combinational load-use comparator, so the EX/MEM stage can reuse the same comparison pattern.

Test Plan:
- Reset with every input nonzero -> next cycle all ex_* = 0 and hazard_stall = 0.
- Normal load: id_rs=8, rf_data1=10, id_imm=0xFFFE, id_zext=0, ctrl has REG_WRITE -> next cycle ex_data1=10, ex_imm=0xFFFFFFFE, ex_ctrl[REG_WRITE]=1.
- Load-use: ex_ctrl[MEM_READ]=1 and ex_rt=9, then an ID instruction with id_rs=9 -> hazard_stall=1 that cycle. Next cycle ex_ctrl=0 and hazard_stall=0.
- Load to $zero: ex_rt=0 with MEM_READ, id_rs=0 -> hazard_stall=0.
- Bypass (WB_BYPASS_EN): wb_write_reg=10, wb_write_data=0x55, rf_data2=22, id_rt=10 -> ex_data2=0x55. Without the macro -> ex_data2=22. With wb_write_reg=0 -> rf data used.
- flush together with ext_stall -> ex_ctrl=0 (flush wins). Then ext_stall alone for 3 cycles -> all ex_* held constant.
